// File: rtl/l_lock_ctrl.sv
// Password-lock controller: assembles 4-digit keypad entries, checks them against a
// stored password, tracks failed attempts and drives unlock/alarm/admin flows.
module l_lock_ctrl #(
  parameter logic [15:0] DEFAULT_PW   = 16'h4321,
  parameter int unsigned MAX_ERR      = 3,
  parameter logic [31:0] TIMEOUT_CYC  = 32'd1_000_000_000,
  parameter logic [31:0] ERR_HOLD_CYC = 32'd200_000_000,
  parameter logic [31:0] UNLOCK_CYC   = 32'd500_000_000,
  parameter logic [31:0] ALARM_CYC    = 32'd1_000_000_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic        BTN_CONFIRM,
  input  logic        BTN_ADMIN,
  output logic [2:0]  Current_State,
  output logic [15:0] Code,
  output logic [3:0]  Error_Times,
  output logic        UNLOCK_OUT,
  output logic        ALARM_OUT
);

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned CODE_W  = 16;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ERR_W   = 4;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_INPUT  = 3'd1;
  localparam logic [2:0] S_UNLOCK = 3'd2;
  localparam logic [2:0] S_ERROR  = 3'd3;
  localparam logic [2:0] S_ALARM  = 3'd4;
  localparam logic [2:0] S_ADMIN  = 3'd5;

  localparam logic [CODE_W-1:0] BLANK      = 16'hAAAA;
  localparam logic [3:0]        KEY_CLEAR  = 4'd11;
  localparam logic [CNT_W-1:0]  FULL_CNT   = 3'd4;
  localparam logic [ERR_W-1:0]  ERR_SAT    = 4'hF;
  localparam logic [ERR_W-1:0]  ERR_LIMIT  = ERR_W'(MAX_ERR);

  logic [2:0]         state_q,  state_d;
  logic [CODE_W-1:0]  code_q,   code_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [ERR_W-1:0]   err_q,    err_d;
  logic [CODE_W-1:0]  pw_q,     pw_d;
  logic [TIMER_W-1:0] timer_q,  timer_d;
  logic               unlock_q, unlock_d;
  logic               alarm_q,  alarm_d;

  logic             key_digit;
  logic             key_clear;
  logic             key_take;
  logic             confirm_full;
  logic [ERR_W-1:0] err_inc;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_WAIT;
      code_q   <= BLANK;
      cnt_q    <= '0;
      err_q    <= '0;
      pw_q     <= DEFAULT_PW;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      pw_q     <= pw_d;
      timer_q  <= timer_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
    end
  end

  // Next-state, entry handling and shared dwell/timeout timer
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    pw_d         = pw_q;
    timer_d      = timer_q + TIMER_W'(1);
    key_take     = 1'b0;
    key_digit    = KEY_VALID && (KEY_CODE <= 4'd9);
    key_clear    = KEY_VALID && (KEY_CODE == KEY_CLEAR);
    confirm_full = BTN_CONFIRM && (cnt_q == FULL_CNT);
    err_inc      = (err_q == ERR_SAT) ? ERR_SAT : err_q + ERR_W'(1);

    case (state_q)
      S_WAIT: begin
        if (key_digit) begin
          state_d = S_INPUT;
          code_d  = {BLANK[CODE_W-1:4], KEY_CODE};
          cnt_d   = CNT_W'(1);
        end else if (key_clear) begin
          code_d = BLANK;
          cnt_d  = '0;
        end
      end

      S_INPUT, S_ADMIN: begin
        // Confirm wins over a same-cycle key, so the compare sees the pre-key entry
        if (confirm_full) begin
          if (state_q == S_ADMIN) begin
            pw_d    = code_q;
            state_d = S_WAIT;
            code_d  = BLANK;
            cnt_d   = '0;
          end else if (code_q == pw_q) begin
            state_d = S_UNLOCK;
            err_d   = '0;
          end else begin
            err_d   = err_inc;
            state_d = (err_inc >= ERR_LIMIT) ? S_ALARM : S_ERROR;
          end
        end else if (key_digit && (cnt_q < FULL_CNT)) begin
          code_d[{cnt_q[1:0], 2'b00} +: 4] = KEY_CODE;
          cnt_d    = cnt_q + CNT_W'(1);
          key_take = 1'b1;
        end else if (key_clear) begin
          code_d   = BLANK;
          cnt_d    = '0;
          key_take = 1'b1;
        end else if (timer_q == TIMEOUT_CYC - TIMER_W'(1)) begin
          state_d = S_WAIT;
          code_d  = BLANK;
          cnt_d   = '0;
        end
      end

      S_UNLOCK: begin
        if (BTN_ADMIN) begin
          state_d = S_ADMIN;
          code_d  = BLANK;
          cnt_d   = '0;
        end else if (timer_q == UNLOCK_CYC - TIMER_W'(1)) begin
          state_d = S_WAIT;
          code_d  = BLANK;
          cnt_d   = '0;
        end
      end

      S_ERROR: begin
        if (timer_q == ERR_HOLD_CYC - TIMER_W'(1)) begin
          state_d = S_INPUT;
          code_d  = BLANK;
          cnt_d   = '0;
        end
      end

      S_ALARM: begin
        if (timer_q == ALARM_CYC - TIMER_W'(1)) begin
          state_d = S_WAIT;
          err_d   = '0;
          code_d  = BLANK;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_WAIT;
        code_d  = BLANK;
        cnt_d   = '0;
      end
    endcase

    if ((state_d != state_q) || key_take) begin
      timer_d = '0;
    end

    unlock_d = (state_d == S_UNLOCK);
    alarm_d  = (state_d == S_ALARM);
  end

  assign Current_State = state_q;
  assign Code          = code_q;
  assign Error_Times   = err_q;
  assign UNLOCK_OUT    = unlock_q;
  assign ALARM_OUT     = alarm_q;

endmodule

// File: doc/l_lock_ctrl.md
Name: l_lock_ctrl

Overview:
- Password-lock controller FSM; the stage directly upstream of the seven-segment display block.
- Consumes single-cycle key pulses from the keypad debouncer and assembles a 4-digit entry.
- Checks the entry against a stored password, counts failures, and drives alarm and admin password change.
- Produces the state code, entry digits and error count that the display block renders.

Parameters:
- DEFAULT_PW, 16'h4321: password loaded at reset. Nibble 0 is the first digit; each nibble is 0-9.
- MAX_ERR, 3: failed attempts that trigger ALARM (1..15).
- TIMEOUT_CYC, 32'd1_000_000_000: idle cycles in INPUT/ADMIN before returning to WAIT.
- ERR_HOLD_CYC, 32'd200_000_000: dwell time in ERROR.
- UNLOCK_CYC, 32'd500_000_000: dwell time in UNLOCK.
- ALARM_CYC, 32'd1_000_000_000: dwell time in ALARM.

Ports:
- CLK, input, 1: system clock.
- RST_N, input, 1: asynchronous active-low reset.
- KEY_VALID, input, 1: one-cycle pulse; KEY_CODE is valid this cycle.
- KEY_CODE, input, 4: 0-9 digit; 11 = clear/backspace-all; any other value is ignored.
- BTN_CONFIRM, input, 1: one-cycle confirm pulse.
- BTN_ADMIN, input, 1: one-cycle admin-request pulse.
- Current_State, output, 3: WAIT=0, INPUT=1, UNLOCK=2, ERROR=3, ALARM=4, ADMIN=5.
- Code, output, 16: entry digits, nibble k = k-th entered digit; an unentered nibble reads 4'hA (blank).
- Error_Times, output, 4: consecutive failed attempts.
- UNLOCK_OUT, output, 1: high while in UNLOCK.
- ALARM_OUT, output, 1: high while in ALARM.

Behaviour:
- Reset (async, RST_N low):
  - Current_State=WAIT, Code=16'hAAAA, Error_Times=0, UNLOCK_OUT=0, ALARM_OUT=0.
  - Digit count=0, timer=0, password register=DEFAULT_PW.
  - Reset mid-entry or mid-alarm aborts immediately.
- All outputs are registered. A state change is visible the cycle after the causing pulse.
- One 32-bit timer is shared by all states. It clears on every state change and on every accepted key in INPUT/ADMIN, and increments otherwise.
- Digit append: a digit key with count<4 writes nibble[count] and increments count. With count==4, further digits are ignored.
- Clear (KEY_CODE=11): Code=16'hAAAA, count=0. State is unchanged.
- WAIT:
  - A digit key goes to INPUT with that digit stored in nibble 0, count=1.
  - BTN_CONFIRM and BTN_ADMIN are ignored.
- INPUT:
  - BTN_CONFIRM with count<4 is ignored.
  - BTN_CONFIRM with count==4 compares Code to the password.
    - Match: go to UNLOCK, Error_Times=0.
    - Mismatch: Error_Times+1; go to ALARM if the new value ≥ MAX_ERR, else ERROR.
  - If timer reaches TIMEOUT_CYC-1: go to WAIT, Code blanked, count=0. Error_Times is kept.
- ERROR: after ERR_HOLD_CYC cycles, go to INPUT with Code blanked and count=0. Keys are ignored.
- UNLOCK:
  - BTN_ADMIN goes to ADMIN with Code blanked and count=0.
  - Otherwise, after UNLOCK_CYC cycles, go to WAIT with Code blanked.
- ADMIN:
  - Digit and clear keys behave as in INPUT.
  - BTN_CONFIRM with count==4 writes the password register from Code, then goes to WAIT with Code blanked.
  - Timeout returns to WAIT with the password unchanged.
- ALARM:
  - ALARM_OUT=1 and all inputs are ignored.
  - After ALARM_CYC cycles, go to WAIT with Error_Times=0 and Code blanked.
- Simultaneous events in one cycle:
  - BTN_CONFIRM beats KEY_VALID: the comparison uses the pre-key Code and the key is dropped.
  - BTN_ADMIN beats the UNLOCK timer expiry.
- Error_Times saturates at 15 and never wraps.
- State codes 6 and 7 are unreachable; if entered, recover to WAIT on the next cycle.

Test Plan:
- Setup: TIMEOUT_CYC=50, ERR_HOLD_CYC=5, UNLOCK_CYC=10, ALARM_CYC=20.
- Keys 1,2,3,4 then CONFIRM:
  - Code=16'h4321 and Current_State=2 the cycle after CONFIRM.
  - UNLOCK_OUT=1 for 10 cycles, then state=0, Code=16'hAAAA.
- Keys 1,1,1,1 then CONFIRM, three times:
  - After the 1st and 2nd: state=3 for 5 cycles, then state=1 with Error_Times=1, then 2.
  - After the 3rd: state=4, ALARM_OUT=1 for 20 cycles, then state=0 with Error_Times=0.
- Admin change:
  - Unlock, then BTN_ADMIN: state=5.
  - Keys 9,8,7,6 then CONFIRM: state=0.
  - Re-entering 9,8,7,6: state=2. Entering 1,2,3,4: state=3.
- Entry handling:
  - Keys 5,6 then CONFIRM: ignored, state stays 1.
  - KEY_CODE=11: Code=16'hAAAA.
  - Five digit keys: only the first four are stored.
  - Idle 50 cycles: state=0.
- Corner cases:
  - KEY_VALID and BTN_CONFIRM in the same cycle with count==4: the comparison ignores the new key.
  - RST_N pulsed low mid-ALARM: all outputs return to reset values asynchronously, and the password reverts to 16'h4321.
